// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch-stage next-PC generator with EX redirect and return-address stack
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      hold PC and freeze ID-side RAS actions
//   id_call, id_ret, id_pc     call/return decoded at ID and its PC
//   ex_valid, ex_op, ex_pc     EX instruction: valid, target kind, PC
//   ex_imm, ex_base            immediate and rs1 value for target computation
//   ex_pred_npc                next PC the front end followed after the EX instruction
//   if_pc, if_pc4              fetch PC (registered) and fetch PC + 4
//   ras_pred, ras_empty        RAS top and RAS empty flag
//   ex_npc, ex_link            resolved next PC and link value of the EX instruction
//   ex_flush, id_flush         kill IF+ID on mispredict; kill IF on RAS redirect
module pc_gen_ras #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            id_call,
    input  logic            id_ret,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ex_valid,
    input  logic [1:0]      ex_op,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_base,
    input  logic [XLEN-1:0] ex_pred_npc,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] ras_pred,
    output logic [XLEN-1:0] ex_npc,
    output logic [XLEN-1:0] ex_link,
    output logic            ex_flush,
    output logic            id_flush,
    output logic            ras_empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] FULL = RAS_DEPTH[PW:0];
    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top;
    logic [PW:0]     cnt;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link_id;
    logic            ras_en;
    always_comb begin
        top      = ptr - 1'b1;
        ras_pred = ras[top];
        if_pc4   = if_pc + 4;
        ex_link  = ex_pc + 4;
        link_id  = id_pc + 4;
        jalr_sum = ex_base + ex_imm;
        ex_npc   = ex_op == 2'd1 ? ex_pc + ex_imm :
                   ex_op == 2'd2 ? {jalr_sum[XLEN-1:1], 1'b0} : ex_link;
        ex_flush = ex_valid && (ex_npc != ex_pred_npc);
        ras_en   = !stall && !ex_flush;
        // a return only redirects when the stack has something to predict from
        id_flush = id_ret && (cnt != '0) && ras_en;
        ras_empty = cnt == '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc <= RESET_PC;
            ptr   <= '0;
            cnt   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
        end else begin
            if_pc <= ex_flush ? ex_npc : id_flush ? ras_pred : stall ? if_pc : if_pc4;
            if (ras_en) begin
                // call+return swaps the top in place; on an empty stack it degrades to a push
                if (id_call && id_ret && cnt != '0) begin
                    ras[top] <= link_id;
                end else if (id_call) begin
                    ras[ptr] <= link_id;
                    ptr      <= ptr + 1'b1;
                    cnt      <= cnt == FULL ? cnt : cnt + 1'b1;
                end else if (id_ret && cnt != '0) begin
                    ptr <= top;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_gen_ras.sv
// tb_pc_gen_ras: randomized and directed check of pc_gen_ras against a queue-based reference model
module tb_pc_gen_ras;
    localparam int D = 4;
    logic        clk = 0, rst_n = 0, stall = 0, id_call = 0, id_ret = 0, ex_valid = 0;
    logic [1:0]  ex_op = 0;
    logic [31:0] id_pc = 0, ex_pc = 0, ex_imm = 0, ex_base = 0, ex_pred_npc = 0;
    logic [31:0] if_pc, if_pc4, ras_pred, ex_npc, ex_link;
    logic        ex_flush, id_flush, ras_empty;
    int          total = 0, bad = 0;
    logic [31:0] m_pc = 0;
    logic [31:0] q[$];
    pc_gen_ras #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .id_call(id_call), .id_ret(id_ret),
        .id_pc(id_pc), .ex_valid(ex_valid), .ex_op(ex_op), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_base(ex_base), .ex_pred_npc(ex_pred_npc), .if_pc(if_pc), .if_pc4(if_pc4),
        .ras_pred(ras_pred), .ex_npc(ex_npc), .ex_link(ex_link), .ex_flush(ex_flush),
        .id_flush(id_flush), .ras_empty(ras_empty)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] m_npc();
        case (ex_op)
            2'd1:    return ex_pc + ex_imm;
            2'd2:    return (ex_base + ex_imm) & 32'hffff_fffe;
            default: return ex_pc + 4;
        endcase
    endfunction
    task automatic idle();
        stall = 0; id_call = 0; id_ret = 0; ex_valid = 0; ex_op = 0;
        id_pc = 0; ex_pc = 0; ex_imm = 0; ex_base = 0; ex_pred_npc = 0;
    endtask
    // called at negedge with inputs set: check outputs, advance one clock, update model
    task automatic cyc();
        logic [31:0] n;
        logic        exf, idf;
        #1;
        n   = m_npc();
        exf = ex_valid && (n != ex_pred_npc);
        idf = id_ret && q.size() != 0 && !stall && !exf;
        chk("if_pc", if_pc, m_pc);
        chk("if_pc4", if_pc4, m_pc + 4);
        chk("ex_npc", ex_npc, n);
        chk("ex_link", ex_link, ex_pc + 4);
        chk("ex_flush", ex_flush, exf);
        chk("id_flush", id_flush, idf);
        chk("ras_empty", ras_empty, q.size() == 0);
        if (q.size() != 0) chk("ras_pred", ras_pred, q[$]);
        @(posedge clk);
        m_pc = exf ? n : idf ? q[$] : stall ? m_pc : m_pc + 4;
        if (!stall && !exf) begin
            if (id_call && id_ret && q.size() != 0) q[q.size()-1] = id_pc + 4;
            else if (id_call) begin
                q.push_back(id_pc + 4);
                if (q.size() > D) void'(q.pop_front());
            end else if (id_ret && q.size() != 0) void'(q.pop_back());
        end
        @(negedge clk);
    endtask
    initial begin
        idle();
        #12;
        chk("rst if_pc", if_pc, 0);
        chk("rst empty", ras_empty, 1);
        chk("rst ex_flush", ex_flush, 0);
        chk("rst id_flush", id_flush, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            chk("seq pc", if_pc, i * 4);
            cyc();
        end
        chk("seq pc", if_pc, 12);
        for (int i = 0; i < 20 && m_pc != 32'h20; i++) cyc();
        chk("reach 0x20", if_pc, 32'h20);
        stall = 1;
        cyc();
        cyc();
        chk("stall hold", if_pc, 32'h20);
        ex_valid = 1; ex_op = 1; ex_pc = 32'h10; ex_imm = 32'h40; ex_pred_npc = 32'h14;
        #1 chk("flush under stall", ex_flush, 1);
        cyc();
        chk("branch redirect", if_pc, 32'h50);
        stall = 0; ex_op = 2; ex_base = 32'h103; ex_imm = 32'h4; ex_pred_npc = 32'h106;
        #1 chk("jalr npc", ex_npc, 32'h106);
        chk("jalr ok", ex_flush, 0);
        cyc();
        ex_pred_npc = 32'h200;
        #1 chk("jalr mispred", ex_flush, 1);
        cyc();
        chk("jalr redirect", if_pc, 32'h106);
        idle();
        for (int i = 1; i <= 5; i++) begin
            id_call = 1; id_pc = i * 32'h100;
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            id_ret = 1;
            #1 chk("ret pred", ras_pred, (5 - i) * 32'h100 + 4);
            chk("ret flush", id_flush, 1);
            cyc();
        end
        #1 chk("pop empty flush", id_flush, 0);
        chk("pop empty", ras_empty, 1);
        cyc();
        idle();
        id_call = 1; id_pc = 32'h300;
        cyc();
        idle();
        id_ret = 1; ex_valid = 1; ex_op = 1; ex_pc = 32'h40; ex_imm = 32'h8; ex_pred_npc = 32'h0;
        cyc();
        chk("ex over ras", if_pc, 32'h48);
        chk("ras kept", ras_empty, 0);
        idle();
        stall = 1; id_ret = 1;
        cyc();
        chk("stall ret hold", if_pc, 32'h48);
        chk("stall ras top", ras_pred, 32'h304);
        idle();
        id_call = 1; id_ret = 1; id_pc = 32'h80;
        #1 chk("swap flush", id_flush, 1);
        cyc();
        chk("swap redirect", if_pc, 32'h304);
        chk("swap top", ras_pred, 32'h84);
        chk("swap count", ras_empty, 0);
        idle();
        for (int i = 0; i < 400; i++) begin
            stall   = ($urandom % 4) == 0;
            id_call = ($urandom % 5) == 0;
            id_ret  = ($urandom % 4) == 0;
            id_pc   = $urandom & 32'hffff_fffc;
            ex_valid = $urandom % 2;
            ex_op   = 2'($urandom % 4);
            ex_pc   = $urandom & 32'hffff_fffc;
            ex_imm  = $urandom_range(0, 4095) - 2048;
            ex_base = $urandom;
            ex_pred_npc = ($urandom % 2) ? m_npc() : $urandom;
            cyc();
        end
        idle();
        id_call = 1; id_pc = 32'h700;
        cyc();
        idle();
        @(posedge clk);
        #3 rst_n = 0;
        #1 chk("async rst pc", if_pc, 0);
        chk("async rst empty", ras_empty, 1);
        m_pc = 0;
        q.delete();
        @(negedge clk);
        rst_n = 1;
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
